// File: rtl/fibo_controller_if.sv
// -----------------------------------------------------------------------------
// fibo_controller_if
//
// Bundle of every non-clock signal between the Fibonacci sequencer and its
// surroundings (the requester and the 4-register datapath).
//
// Handshake: a request is a single cycle of start = 1 with n valid, accepted
// only while busy = 0. busy stays high from the accepting edge until the
// sequencer is back in IDLE. done = 1 marks the cycle(s) where data_out
// holds F(n). With FIBO_CTRL_ACK_EN it holds until ack = 1 is sampled;
// without it done is a one-cycle pulse and ack is ignored.
//
// Signals:
//   start, n, ack         requester -> controller
//   zero_flag             datapath  -> controller (ALU result == 0)
//   wrt_adder, wrt_en,
//   load_data, count      controller -> register-file write port
//   rd_addr1, rd_addr2,
//   alu_opcode            controller -> ALU operand select / operation
//   busy, done            controller -> requester
//
// Modports: master = controller side, slave = requester/datapath side.
// -----------------------------------------------------------------------------
interface fibo_controller_if #(
  parameter int size = 4
);
  logic            start;
  logic [size-1:0] n;
  logic            ack;
  logic            zero_flag;
  logic [1:0]      wrt_adder;
  logic            wrt_en;
  logic            load_data;
  logic [1:0]      rd_addr1;
  logic [1:0]      rd_addr2;
  logic [2:0]      alu_opcode;
  logic [size-1:0] count;
  logic            busy;
  logic            done;

  modport master (
    input  start, n, ack, zero_flag,
    output wrt_adder, wrt_en, load_data, rd_addr1, rd_addr2,
           alu_opcode, count, busy, done
  );

  modport slave (
    output start, n, ack, zero_flag,
    input  wrt_adder, wrt_en, load_data, rd_addr1, rd_addr2,
           alu_opcode, count, busy, done
  );
endinterface

// File: rtl/fibo_controller.sv
// -----------------------------------------------------------------------------
// fibo_controller
//
// Moore sequencer for a 4-register Fibonacci datapath. After a start request
// it seeds the register file (R0 = 0, R1 = 1, R2 = 1, R3 = n) and then
// alternates a decrement of R3 with an add of the R0/R1 pair until the
// decrement reaches zero. The result, F(n) mod 2^size, is left on the
// datapath's data_out by reading the newest pair register through a PASS.
//
// Register roles: R0/R1 Fibonacci pair, R2 constant 1, R3 remaining count.
// The 'last' flop records which of R0/R1 holds the newest value.
//
// Ports:
//   Clk        clock, all state changes on the rising edge
//   Rst        synchronous active-high reset (wins over start)
//   bus        fibo_controller_if.master, see the interface for signals
//   state_dbg  current FSM state for observation
//
// Optional feature: define FIBO_CTRL_ACK_EN to hold DONE until ack = 1.
// -----------------------------------------------------------------------------
module fibo_controller #(
  parameter int size = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  fibo_controller_if.master         bus,
  output logic [3:0]                state_dbg
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT0 = 4'd1,
    INIT1 = 4'd2,
    INIT2 = 4'd3,
    INIT3 = 4'd4,
    DEC   = 4'd5,
    STEP  = 4'd6,
    OUT   = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            last;
  logic [size-1:0] n_q;

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture and newest-pair tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      n_q  <= '0;
      last <= 1'b0;
    end else begin
      // n is taken only with an accepted request and held while busy.
      if (state == IDLE && bus.start) begin
        n_q <= bus.n;
      end
      // n = 0 reports R0 (= 0) directly; otherwise R1 (= 1) is newest.
      if (state == INIT3) begin
        last <= (n_q != '0);
      end
      // The add overwrote the older pair register, so it is now the newest.
      if (state == STEP) begin
        last <= ~last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    bus.wrt_adder  = 2'd0;
    bus.wrt_en     = 1'b0;
    bus.load_data  = 1'b0;
    bus.rd_addr1   = {1'b0, last};
    bus.rd_addr2   = 2'd0;
    bus.alu_opcode = OP_PASS;
    bus.count      = '0;
    bus.busy       = (state != IDLE);
    bus.done       = 1'b0;

    unique case (state)
      IDLE: begin
        // PASS of the newest pair register keeps the last result visible.
        if (bus.start) begin
          state_next = INIT0;
        end
      end

      INIT0: begin
        bus.wrt_en    = 1'b1;
        bus.load_data = 1'b1;
        bus.wrt_adder = 2'd0;
        bus.count     = '0;
        state_next    = INIT1;
      end

      INIT1: begin
        bus.wrt_en    = 1'b1;
        bus.load_data = 1'b1;
        bus.wrt_adder = 2'd1;
        bus.count     = size'(1);
        state_next    = INIT2;
      end

      INIT2: begin
        bus.wrt_en    = 1'b1;
        bus.load_data = 1'b1;
        bus.wrt_adder = 2'd2;
        bus.count     = size'(1);
        state_next    = INIT3;
      end

      INIT3: begin
        bus.wrt_en    = 1'b1;
        bus.load_data = 1'b1;
        bus.wrt_adder = 2'd3;
        bus.count     = n_q;
        state_next    = (n_q == '0) ? OUT : DEC;
      end

      DEC: begin
        // R3 <= R3 - R2. zero_flag reflects this subtraction, so a zero
        // means the final add has already been done.
        bus.rd_addr1   = 2'd3;
        bus.rd_addr2   = 2'd2;
        bus.alu_opcode = OP_SUB;
        bus.wrt_en     = 1'b1;
        bus.wrt_adder  = 2'd3;
        state_next     = bus.zero_flag ? OUT : STEP;
      end

      STEP: begin
        // R(~last) <= R0 + R1; the older register takes the new sum.
        bus.rd_addr1   = 2'd0;
        bus.rd_addr2   = 2'd1;
        bus.alu_opcode = OP_ADD;
        bus.wrt_en     = 1'b1;
        bus.wrt_adder  = {1'b0, ~last};
        state_next     = DEC;
      end

      OUT: begin
        state_next = DONE;
      end

      DONE: begin
        bus.done = 1'b1;
`ifdef FIBO_CTRL_ACK_EN
        if (bus.ack) begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fibo_controller.sv
// -----------------------------------------------------------------------------
// tb_fibo_controller
//
// Drives fibo_controller together with a behavioural 4-register datapath
// (register file written on the rising edge, ALU result latched on the
// falling edge, zero_flag = latched result == 0). Expected results come from
// plain Fibonacci arithmetic and the cycle formula for DONE.
// Compile with +define+FIBO_CTRL_ACK_EN to exercise the acknowledge option.
// -----------------------------------------------------------------------------
module tb_fibo_controller;

  localparam int W = 4;

  logic       Clk;
  logic       Rst;
  logic [3:0] state_dbg;

  fibo_controller_if #(.size(W)) bus ();

  fibo_controller #(.size(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- datapath model ----------------
  logic [W-1:0] rf [4];
  logic [W-1:0] dp_out;

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = '0;
    dp_out = '0;
  end

  always @(posedge Clk) begin
    if (bus.wrt_en) begin
      rf[bus.wrt_adder] <= bus.load_data ? bus.count : dp_out;
    end
  end

  always @(negedge Clk) begin
    case (bus.alu_opcode)
      3'b001:  dp_out <= rf[bus.rd_addr1] + rf[bus.rd_addr2];
      3'b010:  dp_out <= rf[bus.rd_addr1] - rf[bus.rd_addr2];
      default: dp_out <= rf[bus.rd_addr1];
    endcase
  end

  assign bus.zero_flag = (dp_out == '0);

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fib_mod(input int k);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return W'(a % (1 << W));
  endfunction

  function automatic int done_cycle(input int k);
    return (k == 0) ? 5 : 2 * k + 4;
  endfunction

  // ---------------- driver tasks ----------------
  // Sample / drive point: 1 time unit after the falling edge.
  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  // Issues a one-cycle start; returns at the sample point of cycle 0.
  task automatic start_run(input int nv);
    bus.start = 1'b1;
    bus.n     = W'(nv);
    exp_q.push_back(fib_mod(nv));
    step();
    bus.start = 1'b0;
    bus.n     = W'($urandom_range(0, 15));
  endtask

  // Follows a run to DONE; optionally pokes start with n = 3 at cycle poke_c.
  task automatic wait_done(input int nv, input int poke_c, input string tag);
    int   got_c;
    bit   busy_ok;
    logic [W-1:0] exp_v;
    got_c   = -1;
    busy_ok = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (c == poke_c) begin
        bus.start = 1'b1;
        bus.n     = 4'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        got_c = c;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      step();
    end
    bus.start = 1'b0;
    chk({tag, "_done_cycle"}, got_c, done_cycle(nv));
    chk({tag, "_busy_run"}, busy_ok, 1);
    chk({tag, "_busy_at_done"}, bus.busy, 1);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_data_out"}, dp_out, exp_v);
  endtask

  // Leaves DONE and checks the result stays visible in IDLE.
  task automatic finish_run(input int nv, input string tag);
`ifdef FIBO_CTRL_ACK_EN
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
`else
    step();
`endif
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_idle_done"}, bus.done, 0);
    step();
    chk({tag, "_idle_data"}, dp_out, fib_mod(nv));
  endtask

  task automatic full_run(input int nv, input string tag);
    start_run(nv);
    wait_done(nv, -1, tag);
    finish_run(nv, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  rn;
    bit  seen;
    Rst       = 1'b1;
    bus.start = 1'b1;
    bus.n     = 4'd5;
    bus.ack   = 1'b0;
    step();
    step();

    // Reset held with start high: reset must win.
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wrt_en", bus.wrt_en, 0);
    chk("rst_load_data", bus.load_data, 0);
    chk("rst_wrt_adder", bus.wrt_adder, 0);
    chk("rst_rd_addr1", bus.rd_addr1, 0);
    chk("rst_rd_addr2", bus.rd_addr2, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_alu_opcode", bus.alu_opcode, 0);
    Rst       = 1'b0;
    bus.start = 1'b0;
    step();
    chk("post_rst_busy", bus.busy, 0);

    // Directed cases.
    full_run(7, "n7");
    full_run(0, "n0");
    full_run(1, "n1");
    full_run(10, "n10");
    full_run(15, "n15");

    // Restart during a run is ignored.
    start_run(7);
    wait_done(7, 6, "restart");
    finish_run(7, "restart");

    // Reset mid-run: back to IDLE, no done.
    start_run(7);
    void'(exp_q.pop_back());
    for (int c = 0; c < 9; c++) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      step();
    end
    chk("midrst_quiet", seen, 0);

`ifdef FIBO_CTRL_ACK_EN
    // DONE holds while ack is low; start during DONE is ignored.
    start_run(6);
    wait_done(6, -1, "ack_n6");
    for (int c = 0; c < 5; c++) begin
      bus.start = (c < 3);
      bus.n     = 4'd2;
      step();
      chk("ack_hold_done", bus.done, 1);
      chk("ack_hold_data", dp_out, 8);
    end
    bus.start = 1'b0;
    finish_run(6, "ack_n6");
`else
    // ack has no effect when the option is off.
    bus.ack = 1'b1;
    full_run(6, "ack_ignored");
    bus.ack = 1'b0;
`endif

    // Random requests.
    for (int i = 0; i < 12; i++) begin
      rn = $urandom_range(0, 15);
      full_run(rn, $sformatf("rand%0d_n%0d", i, rn));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
